seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder/subtractor, successor to the fixed 4-bit ripple adder. It processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, through one shared CHUNK-bit ripple stage. It takes operands and returns results over valid/ready handshakes, and reports carry-out and signed overflow. It serves as the area-lean arithmetic unit for datapaths that tolerate multi-cycle latency.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 2.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0, otherwise elaboration fails.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand request
in_ready  out  1  block can accept; high only in IDLE
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in for add; borrow-in for subtract
sub  in  1  0: A+B+cin; 1: A-B-cin
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result, two's-complement wrap
cout  out  1  carry out of MSB; for sub, 1 = no borrow
ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE, out_valid 0, sum 0, cout 0, ovf 0, chunk counter 0. in_ready decodes state and is 1 out of reset.
- NCHUNK = WIDTH/CHUNK. The counter width is clog2(NCHUNK), minimum 1.
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready, capture a, b_eff = sub ? ~b : b, and carry = cin ^ sub. Clear the counter and go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle, add chunk k of a and b_eff with the carry register. Write the CHUNK-bit result into sum bits [k*CHUNK +: CHUNK] and update the carry. When k == NCHUNK-1, also latch the carry into the MSB, set cout/ovf, and go to DONE. Otherwise increment k.
  - DONE: out_valid=1. sum, cout and ovf are held stable. On out_ready, go to IDLE. There is no same-cycle re-accept.
- Latency: out_valid rises NCHUNK edges after the accepting edge. Throughput is one operation per NCHUNK+2 cycles with out_ready tied high.
- sum, cout and ovf change only in RUN. They keep the previous result in IDLE until overwritten chunk by chunk.
- in_valid is ignored outside IDLE. a, b, cin and sub are sampled only at accept and may change afterwards.
- Backpressure: DONE holds indefinitely while out_ready=0.
- Reset mid-operation aborts immediately and asynchronously: state returns to IDLE, out_valid=0, outputs return to reset values, and the partial result is discarded.
- CHUNK == WIDTH: the RUN state lasts exactly 1 cycle. CHUNK == 1: bit-serial operation, WIDTH cycles.
- sub with cin=1 gives A-B-1, the borrow-in used for chaining.

Decomposition:
- Package seq_chunk_adder_pkg: FSM state enum {IDLE, RUN, DONE}, and a clog2-based counter-width function.
- Sub-module chunk_ripple_adder, parameter N:
  - inputs: a[N], b[N], ci
  - outputs: s[N], co, c_msb (carry into bit N-1)
  - purely combinational ripple of full adders
  - instantiated once with N=CHUNK

Test Plan:
- WIDTH=32, CHUNK=4: a=0xFFFFFFFF, b=0x1, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0. out_valid rises exactly 8 edges after accept.
- a=0x7FFFFFFF, b=0x1, add -> sum=0x80000000, cout=0, ovf=1. a=0x80000000, b=0xFFFFFFFF -> sum=0x7FFFFFFF, cout=1, ovf=1.
- sub=1, cin=0: a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0. a=7, b=5 -> sum=0x2, cout=1. With cin=1, a=7, b=5 -> sum=0x1.
- Backpressure:
  - hold out_ready=0 for 5 cycles after out_valid -> sum/cout/ovf stable, in_ready=0, and a new in_valid is not accepted;
  - raise out_ready -> IDLE and in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 during RUN at chunk 3 -> out_valid=0, in_ready=1, sum=0 without a clock edge. The next operation, 0x12345678+0x11111111, gives 0x23456789.
- Degenerate configurations: WIDTH=8 with CHUNK=1 and with CHUNK=8, 0x80+0x80 -> sum=0x00, cout=1, ovf=1. Latency is 8 and 1 respectively.

Source files
------------

// File: rtl/seq_chunk_adder_pkg.sv
// seq_chunk_adder_pkg: shared FSM state type and chunk-counter width helper
package seq_chunk_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chunk_ripple_adder.sv
// chunk_ripple_adder: combinational N-bit ripple adder exposing carry into its MSB
module chunk_ripple_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb
);
  logic [N:0] c;
  // full-adder chain, LSB first
  always_comb begin
    c = '0;
    s = '0;
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      s[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[N];
    c_msb = c[N-1];
  end
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/sub, CHUNK bits per clock through one shared ripple stage
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("seq_chunk_adder: illegal WIDTH/CHUNK combination");
  end
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = cnt_w(NCHUNK);
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);
  state_t state, state_n;
  logic [KW-1:0] k;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry, co, c_msb;
  logic [CHUNK-1:0] s;
  chunk_ripple_adder #(.N(CHUNK)) u_rip (
    .a(a_r[k*CHUNK +: CHUNK]),
    .b(b_r[k*CHUNK +: CHUNK]),
    .ci(carry),
    .s(s),
    .co(co),
    .c_msb(c_msb)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state and handshake outputs
  always_comb begin
    state_n = (state == IDLE && in_valid) ? RUN :
              (state == RUN && k == KLAST) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  // operand capture and chunk-by-chunk accumulation; subtract folds into ~b with carry-in flipped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      k <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= sub ? ~b : b;
      carry <= cin ^ sub;
      k <= '0;
    end else if (state == RUN) begin
      sum[k*CHUNK +: CHUNK] <= s;
      carry <= co;
      if (k == KLAST) begin
        cout <= co;
        ovf <= co ^ c_msb;
      end else k <= k + KW'(1);
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed vectors on 32/4, 8/1 and 8/8 configurations
module tb_seq_chunk_adder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic cin_in = 1'b0, sub_in = 1'b0;
  logic iv[3], ordy[3], ir[3], ov[3], co[3], of[3];
  logic [31:0] s32;
  logic [7:0] s8a, s8b;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_in), .b(b_in),
    .cin(cin_in), .sub(sub_in), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s32), .cout(co[0]), .ovf(of[0]));
  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u8s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin_in), .sub(sub_in), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s8a), .cout(co[1]), .ovf(of[1]));
  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u8w (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin_in), .sub(sub_in), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s8b), .cout(co[2]), .ovf(of[2]));

  function automatic logic [31:0] gsum(input int d);
    return d == 0 ? s32 : d == 1 ? {24'b0, s8a} : {24'b0, s8b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one operation on instance d; hold extra DONE cycles with a competing request before releasing
  task automatic op(input int d, input logic [31:0] x, input logic [31:0] y, input logic ci,
                    input logic sb, input logic [31:0] es, input logic ec, input logic eo,
                    input int elat, input int hold, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, "_ready"}, {31'b0, ir[d]}, 1);
    a_in = x; b_in = y; cin_in = ci; sub_in = sb; iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ov[d] && lat < 200);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_sum"}, gsum(d), es);
    chk({tag, "_cout"}, {31'b0, co[d]}, {31'b0, ec});
    chk({tag, "_ovf"}, {31'b0, of[d]}, {31'b0, eo});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a_in = 32'hDEAD_BEEF; b_in = 32'h0BAD_F00D; iv[d] = 1'b1;
      chk({tag, "_hold_sum"}, gsum(d), es);
      chk({tag, "_hold_flags"}, {30'b0, co[d], of[d]}, {30'b0, ec, eo});
      chk({tag, "_hold_hs"}, {30'b0, ov[d], ir[d]}, 32'b10);
    end
    @(negedge clk);
    iv[d] = 1'b0; ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    chk({tag, "_release"}, {30'b0, ov[d], ir[d]}, 32'b01);
    chk({tag, "_idle_sum"}, gsum(d), es);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
    end
    #12;
    chk("rst_hs", {30'b0, ov[0], ir[0]}, 32'b01);
    chk("rst_sum", s32, 0);
    chk("rst_flags", {30'b0, co[0], of[0]}, 0);
    @(negedge clk); rst_n = 1'b1;
    op(0, 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0, 8, 0, "wrap");
    op(0, 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1, 8, 0, "posovf");
    op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h7FFF_FFFF, 1, 1, 8, 0, "negovf");
    op(0, 32'd5, 32'd7, 0, 1, 32'hFFFF_FFFE, 0, 0, 8, 0, "sub5m7");
    op(0, 32'd7, 32'd5, 0, 1, 32'h2, 1, 0, 8, 0, "sub7m5");
    op(0, 32'd7, 32'd5, 1, 1, 32'h1, 1, 0, 8, 0, "sub7m5b");
    op(0, 32'h10, 32'h20, 0, 0, 32'h30, 0, 0, 8, 5, "bp");
    // abort during RUN with chunk counter at 3
    @(negedge clk);
    a_in = 32'h1111_1111; b_in = 32'h1111_1111; cin_in = 0; sub_in = 0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_partial", s32, 32'h0000_0222);
    rst_n = 1'b0;
    #1;
    chk("abort_hs", {30'b0, ov[0], ir[0]}, 32'b01);
    chk("abort_sum", s32, 0);
    @(negedge clk); rst_n = 1'b1;
    op(0, 32'h1234_5678, 32'h1111_1111, 0, 0, 32'h2345_6789, 0, 0, 8, 0, "post_abort");
    op(1, 32'h80, 32'h80, 0, 0, 32'h00, 1, 1, 8, 0, "serial");
    op(2, 32'h80, 32'h80, 0, 0, 32'h00, 1, 1, 1, 0, "wide");
    op(1, 32'h05, 32'h07, 0, 1, 32'hFE, 0, 0, 8, 0, "serial_sub");
    op(2, 32'h7F, 32'h01, 0, 0, 32'h80, 0, 1, 1, 0, "wide_ovf");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
